// File: rtl/onehot_demux_buffered.sv
// onehot_demux_buffered
//   Streaming one-hot demultiplexer. A single valid/ready input stream carries
//   a one-hot lane select. Each word is routed into that lane's DEPTH-entry
//   FIFO, and every lane drains through its own valid/ready handshake. A word
//   whose select is not one-hot is still accepted, but it is dropped and
//   err_o pulses in the following cycle.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rst      : asynchronous active-high reset
//   valid_i  : input word valid
//   ready_o  : input word can be accepted this cycle (combinational)
//   sel_i    : one-hot destination lane for data_i
//   data_i   : input word
//   valid_o  : per-lane head entry valid
//   ready_i  : per-lane consumer ready
//   data_o   : per-lane head entry data, lane k at [k*WIDTH +: WIDTH]; zero when lane empty
//   err_o    : one-cycle pulse, a word with a non-one-hot select was discarded
module onehot_demux_buffered #(
  parameter int OUTPUTS = 4,
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [OUTPUTS-1:0]       sel_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [OUTPUTS-1:0]       valid_o,
  input  logic [OUTPUTS-1:0]       ready_i,
  output logic [OUTPUTS*WIDTH-1:0] data_o,
  output logic                     err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // A select is legal when it is nonzero and clearing its lowest set bit leaves zero.
  function automatic logic f_is_onehot(input logic [OUTPUTS-1:0] v);
    logic r;
    r = (v != {OUTPUTS{1'b0}}) &&
        ((v & (v - {{(OUTPUTS-1){1'b0}}, 1'b1})) == {OUTPUTS{1'b0}});
    return r;
  endfunction

  // Pointer increment that wraps at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == LAST_PTR) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1'b1);
    end
    return r;
  endfunction

  logic [WIDTH-1:0]   r_mem    [OUTPUTS][DEPTH];
  logic [PW-1:0]      r_wr_ptr [OUTPUTS];
  logic [PW-1:0]      r_rd_ptr [OUTPUTS];
  logic [CW-1:0]      r_count  [OUTPUTS];
  logic               r_err;

  logic               w_legal;
  logic               w_accept;
  logic               w_err_next;
  logic [OUTPUTS-1:0] w_valid;
  logic [OUTPUTS-1:0] w_pop;
  logic [OUTPUTS-1:0] w_push;
  logic [OUTPUTS-1:0] w_lane_ready;

  // Per-lane status. A full lane still has room when it pops in the same
  // cycle, which gives the combinational ready_i -> ready_o path.
  always_comb begin
    w_valid      = {OUTPUTS{1'b0}};
    w_pop        = {OUTPUTS{1'b0}};
    w_lane_ready = {OUTPUTS{1'b0}};
    for (int k = 0; k < OUTPUTS; k++) begin
      w_valid[k]      = (r_count[k] != {CW{1'b0}});
      w_pop[k]        = w_valid[k] && ready_i[k];
      w_lane_ready[k] = (r_count[k] < FULL_CNT) || w_pop[k];
    end
  end

  // Input handshake and routing. An illegal select is always accepted so that
  // it can be discarded. When valid_i is low, an X on sel_i falls into the
  // else branch and cannot produce a push.
  always_comb begin
    w_legal = f_is_onehot(sel_i);
    if (w_legal) begin
      ready_o = |(sel_i & w_lane_ready);
    end else begin
      ready_o = 1'b1;
    end
    w_accept = valid_i && ready_o;
    if (w_accept && w_legal) begin
      w_push = sel_i;
    end else begin
      w_push = {OUTPUTS{1'b0}};
    end
    w_err_next = w_accept && !w_legal;
  end

  // Lane FIFO storage, pointers, counts and the registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < OUTPUTS; k++) begin
        r_wr_ptr[k] <= {PW{1'b0}};
        r_rd_ptr[k] <= {PW{1'b0}};
        r_count[k]  <= {CW{1'b0}};
        for (int e = 0; e < DEPTH; e++) begin
          r_mem[k][e] <= {WIDTH{1'b0}};
        end
      end
      r_err <= 1'b0;
    end else begin
      for (int k = 0; k < OUTPUTS; k++) begin
        if (w_push[k]) begin
          r_mem[k][r_wr_ptr[k]] <= data_i;
          r_wr_ptr[k]           <= f_next_ptr(r_wr_ptr[k]);
        end
        if (w_pop[k]) begin
          r_rd_ptr[k] <= f_next_ptr(r_rd_ptr[k]);
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CW'(1'b1);
          2'b01:   r_count[k] <= r_count[k] - CW'(1'b1);
          default: r_count[k] <= r_count[k];
        endcase
      end
      r_err <= w_err_next;
    end
  end

  // Head data is gated by lane valid, so an empty lane presents zeros.
  always_comb begin
    data_o = {(OUTPUTS*WIDTH){1'b0}};
    for (int k = 0; k < OUTPUTS; k++) begin
      data_o[k*WIDTH +: WIDTH] = r_mem[k][r_rd_ptr[k]] & {WIDTH{w_valid[k]}};
    end
  end

  assign valid_o = w_valid;
  assign err_o   = r_err;

endmodule

// File: doc/onehot_demux_buffered.md
Name: onehot_demux_buffered

Overview:
- Streaming one-hot demultiplexer: the dispatch-side counterpart of the team's one-hot AND-OR mux.
- Takes a single valid/ready input stream tagged with a one-hot destination select and routes each word to one of OUTPUTS lanes.
- Each lane has its own DEPTH-entry FIFO with an independent valid/ready output handshake.
- Used to fan a shared result bus out to per-lane consumers without head-of-line blocking between idle lanes.

Parameters:
OUTPUTS, 4, number of destination lanes (>=2)
WIDTH, 16, data word width in bits
DEPTH, 2, entries per lane FIFO (>=1; need not be a power of two)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
valid_i  input  1  input word valid
ready_o  output  1  input can be accepted this cycle
sel_i  input  OUTPUTS  one-hot destination lane for data_i
data_i  input  WIDTH  input word
valid_o  output  OUTPUTS  per-lane head entry valid
ready_i  input  OUTPUTS  per-lane consumer ready
data_o  output  OUTPUTS x WIDTH  per-lane head entry data
err_o  output  1  one-cycle pulse: a word with non-one-hot sel_i was discarded

Behaviour:
- Reset (async assert, sync-safe deassert): all lane FIFOs empty, read/write pointers and counts = 0, valid_o = 0, data_o = 0, err_o = 0. Reset mid-transfer discards all buffered words; no partial state survives.
- Lane state: wr_ptr, rd_ptr (0..DEPTH-1, wrap from DEPTH-1 to 0), count (0..DEPTH).
- Pop on lane k: valid_o[k] && ready_i[k]; rd_ptr[k] advances and count decrements.
- valid_o[k] = (count[k] != 0).
- data_o[k] = head entry when valid_o[k]=1, else all zeros (gated per bit by valid, AND-OR style). Purely a function of registered state.
- Legal select: sel_i has exactly one bit set (popcount == 1).
- ready_o for a legal select to lane k: (count[k] < DEPTH) || (valid_o[k] && ready_i[k]).
  - Push into a full lane is allowed when the lane pops in the same cycle.
  - This is a combinational path ready_i -> ready_o.
  - ready_o depends on sel_i and lane state only, never on valid_i.
- ready_o for an illegal select (zero bits or >1 bits set): ready_o = 1.
- Accept: valid_i && ready_o.
  - Legal select: data_i is written at wr_ptr[k], wr_ptr advances and count increments.
  - Simultaneous push+pop on the same lane leaves count unchanged and advances both pointers.
- Illegal accepted word: no lane is written, and err_o = 1 in the following cycle only. Back-to-back illegal words give err_o high on consecutive cycles.
- Latency: a word accepted at edge N is visible on valid_o/data_o after edge N (earliest pop at edge N+1). No same-cycle bypass from data_i to data_o.
- Order: per-lane FIFO order is preserved. There is no ordering guarantee across lanes.
- Independence: a full, stalled lane never affects ready_o for words targeting other lanes.
- Inputs are sampled only when valid_i=1. With valid_i=0, sel_i/data_i may be X without effect; ready_o may then be X-free but is don't-care.
- Throughput: one input word per cycle, plus one pop per lane per cycle.

Test Plan:
- Reset: assert rst mid-cycle with lane 2 holding 2 words -> valid_o=0000, data_o=0, err_o=0 immediately (async). After release, first push to lane 0 appears at the next edge.
- Routing: push 0xA001 with sel=0001, 0xB002 with sel=0100, 0xC003 with sel=1000, all ready_i=1 -> each appears alone on lanes 0/2/3 one cycle after acceptance. Other lanes stay valid_o=0, data_o=0.
- Backpressure/full: ready_i[1]=0, push 0x1111, 0x2222, 0x3333 to sel=0010 (DEPTH=2) -> the first two are accepted and ready_o=0 on the third. Pushing 0x4444 to sel=0001 in that cycle is still accepted. Raising ready_i[1] then pops 0x1111, 0x2222, 0x3333 in order.
- Full with same-cycle pop: lane 1 full, ready_i[1]=1, push 0x5555 to sel=0010 -> ready_o=1, count stays 2, and the head advances to the next word.
- Pointer wrap: stream 7 words 0x0..0x6 through lane 3 with ready_i toggling 1,0,1,0... -> output order 0x0..0x6 with no loss or duplication across the pointer wrap.
- Illegal select: push 0xDEAD with sel=0000, then 0xBEEF with sel=0110 -> both accepted (ready_o=1), no lane valid_o rises, err_o high for exactly the two cycles following the accepts.
